// File: rtl/mmio_pkg.sv
// mmio_pkg: shared register offsets, status bit positions and decode types for the MMIO peripherals
package mmio_pkg;
  localparam logic [2:0] UART_TX_DATA_OFS = 3'd0;
  localparam logic [2:0] UART_TX_STAT_OFS = 3'd4;
  localparam logic [2:0] UART_RX_DATA_OFS = 3'd0;
  localparam logic [2:0] UART_RX_STAT_OFS = 3'd4;
  localparam int STAT_AVAIL = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVR = 2;
  localparam int STAT_CNT_LSB = 8;
  typedef enum logic [1:0] {REG_NONE, REG_DATA, REG_STAT, REG_OTHER} reg_sel_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head, occupancy count and push-while-full-with-pop support
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr && !rst) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: CPU-readable receive FIFO with DATA/STATUS registers and sticky overrun
module uart_rx_mmio
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        cpu_running,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  output logic        rx_irq
);
  reg_sel_e sel;
  logic [2:0] ofs;
  logic [7:0] head;
  logic [AW:0] count;
  logic full, empty, push, pop, ovf, overrun;
  logic [31:0] stat, rd_data_d;
  assign ofs = {rd_addr[2], 2'b00};
  assign push = rx_valid && cpu_running;
  assign pop = sel == REG_DATA && !empty;
  assign ovf = push && full && !pop;
  always_comb begin
    sel = !(rd_en && rd_addr[31:3] == BASE_ADDR[31:3]) ? REG_NONE :
          ofs == UART_RX_DATA_OFS ? REG_DATA :
          ofs == UART_RX_STAT_OFS ? REG_STAT : REG_OTHER;
    stat = '0;
    stat[STAT_AVAIL] = !empty;
    stat[STAT_FULL] = full;
    stat[STAT_OVR] = overrun;
    stat[STAT_CNT_LSB +: 8] = 8'(count);
    rd_data_d = sel == REG_DATA ? (empty ? '0 : {23'b0, 1'b1, head}) :
                sel == REG_STAT ? stat : '0;
  end
  always_ff @(posedge clk) begin
    if (i_reset) begin
      {rd_hit, rd_data, rx_irq, overrun} <= '0;
    end else begin
      rd_hit <= sel != REG_NONE;
      rd_data <= rd_data_d;
      rx_irq <= !empty;
      overrun <= ovf || (overrun && sel != REG_STAT);
    end
  end
  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(i_reset),
    .push(push),
    .pop(pop),
    .din(rx_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule
